// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB direction predictor with 2-bit counters and EX-stage redirect/flush control.
// Optional statistics counters are enabled by defining BPU_STATS_EN.
module branch_predict_unit #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_stall,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_br,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam int unsigned TAG_W   = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit, fire;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[XLEN-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign fire   = ex_valid && ex_is_branch && !ex_stall && !rst;

  // IF lookup reads pre-write table state; reset forces the fall-through prediction.
  always_comb begin
    pred_taken  = !rst && if_hit && ctr_q[if_idx][1];
    pred_target = if_pc + XLEN'(4);
    if (pred_taken) begin
      pred_target = target_q[if_idx];
    end
  end

  // EX resolution: wrong direction or wrong target triggers redirect.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    if (fire) begin
      if (ex_br && (!ex_pred_taken || (ex_pred_target != ex_target))) begin
        redirect    = 1'b1;
        redirect_pc = ex_target;
      end else if (!ex_br && ex_pred_taken) begin
        redirect    = 1'b1;
        redirect_pc = ex_pc + XLEN'(4);
      end
    end
  end

  assign flush = redirect;

  // Table training on each resolution edge.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (fire) begin
      if (ex_hit) begin
        if (ex_br) begin
          ctr_d[ex_idx]    = (ctr_q[ex_idx] == 2'd3) ? 2'd3 : ctr_q[ex_idx] + 2'd1;
          target_d[ex_idx] = ex_target;
        end else begin
          ctr_d[ex_idx] = (ctr_q[ex_idx] == 2'd0) ? 2'd0 : ctr_q[ex_idx] - 2'd1;
        end
      end else if (ex_br) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
        ctr_d[ex_idx]    = 2'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
      ctr_q    <= '{default: 2'd1};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (fire) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end
    if (redirect) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed cycles push expectations, a negedge monitor checks them.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_stall;
  logic [31:0] ex_pc, ex_target;
  logic        ex_br, ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
`ifdef BPU_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_predict_unit #(.IDX_W(4), .XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_stall       (ex_stall),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_br          (ex_br),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush          (flush)
`ifdef BPU_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  typedef struct {
    int          id;
    logic        pt;
    logic [31:0] ptgt;
    logic        rd;
    logic [31:0] rpc;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_id   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, id, act, req);
    end
  endtask

  // Monitor: every sampled cycle presents its outputs; compare against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("pred_taken",  e.id, 32'(pred_taken), 32'(e.pt));
      chk("pred_target", e.id, pred_target, e.ptgt);
      chk("redirect",    e.id, 32'(redirect), 32'(e.rd));
      chk("redirect_pc", e.id, redirect_pc, e.rpc);
      chk("flush",       e.id, 32'(flush), 32'(e.rd));
`ifdef BPU_STATS_EN
      chk("stat_branches",    e.id, stat_branches, e.sb);
      chk("stat_mispredicts", e.id, stat_mispredicts, e.sm);
`endif
    end
  end

  // One cycle of stimulus: drive after the edge, queue the expected same-cycle response.
  task automatic cyc(
    input logic r, input logic [31:0] ipc,
    input logic v, input logic b, input logic st,
    input logic [31:0] epc, input logic [31:0] etgt,
    input logic br, input logic ept, input logic [31:0] eptgt,
    input logic x_pt, input logic [31:0] x_ptgt,
    input logic x_rd, input logic [31:0] x_rpc,
    input logic [31:0] x_sb, input logic [31:0] x_sm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; if_pc = ipc;
    ex_valid = v; ex_is_branch = b; ex_stall = st;
    ex_pc = epc; ex_target = etgt; ex_br = br;
    ex_pred_taken = ept; ex_pred_target = eptgt;
    e.id = cyc_id; e.pt = x_pt; e.ptgt = x_ptgt; e.rd = x_rd; e.rpc = x_rpc;
    e.sb = x_sb; e.sm = x_sm;
    sb_q.push_back(e);
    cyc_id++;
  endtask

  initial begin
    int budget;
    rst = 1'b1; if_pc = 32'h100;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_stall = 1'b0;
    ex_pc = '0; ex_target = '0; ex_br = 1'b0;
    ex_pred_taken = 1'b0; ex_pred_target = '0;
    repeat (2) @(posedge clk);

    //   rst ifpc     v b s ex_pc    ex_tgt   br ept eptgt    | pt ptgt     rd rpc      sb  sm
    cyc(1, 32'h100, 1,1,0, 32'h100, 32'h80,  1, 0, 32'h0,     0, 32'h104,  0, 32'h0,   0,  0);  // in reset, resolution dropped
    cyc(0, 32'h100, 0,0,0, 32'h0,   32'h0,   0, 0, 32'h0,     0, 32'h104,  0, 32'h0,   0,  0);  // first cycle after reset
    cyc(0, 32'h100, 1,1,0, 32'h100, 32'h80,  1, 0, 32'h0,     0, 32'h104,  1, 32'h80,  0,  0);  // cold taken
    cyc(0, 32'h100, 0,0,0, 32'h0,   32'h0,   0, 0, 32'h0,     1, 32'h80,   0, 32'h0,   1,  1);
    cyc(0, 32'h200, 1,1,0, 32'h100, 32'h80,  0, 1, 32'h80,    0, 32'h204,  1, 32'h104, 1,  1);  // predicted taken, fell through
    cyc(0, 32'h100, 0,0,0, 32'h0,   32'h0,   0, 0, 32'h0,     0, 32'h104,  0, 32'h0,   2,  2);  // ctr now 1
    cyc(0, 32'h100, 1,1,0, 32'h100, 32'h80,  1, 1, 32'h80,    0, 32'h104,  0, 32'h0,   2,  2);  // saturation run
    cyc(0, 32'h100, 1,1,0, 32'h100, 32'h80,  1, 1, 32'h80,    1, 32'h80,   0, 32'h0,   3,  2);
    cyc(0, 32'h100, 1,1,0, 32'h100, 32'h80,  1, 1, 32'h80,    1, 32'h80,   0, 32'h0,   4,  2);
    cyc(0, 32'h100, 1,1,0, 32'h100, 32'h80,  1, 1, 32'h80,    1, 32'h80,   0, 32'h0,   5,  2);
    cyc(0, 32'h100, 1,1,0, 32'h100, 32'h80,  1, 1, 32'h80,    1, 32'h80,   0, 32'h0,   6,  2);
    cyc(0, 32'h100, 1,1,0, 32'h100, 32'h80,  0, 1, 32'h80,    1, 32'h80,   1, 32'h104, 7,  2);  // ctr 3 -> 2
    cyc(0, 32'h100, 0,0,0, 32'h0,   32'h0,   0, 0, 32'h0,     1, 32'h80,   0, 32'h0,   8,  3);  // still taken
    cyc(0, 32'h100, 1,1,0, 32'h100, 32'h90,  1, 1, 32'h80,    1, 32'h80,   1, 32'h90,  8,  3);  // target mismatch
    cyc(0, 32'h100, 0,0,0, 32'h0,   32'h0,   0, 0, 32'h0,     1, 32'h90,   0, 32'h0,   9,  4);
    cyc(0, 32'h100, 1,1,1, 32'h100, 32'h0,   0, 1, 32'h90,    1, 32'h90,   0, 32'h0,   9,  4);  // stalled
    cyc(0, 32'h100, 1,0,0, 32'h100, 32'h0,   0, 1, 32'h90,    1, 32'h90,   0, 32'h0,   9,  4);  // non-branch
    cyc(0, 32'h100, 0,1,0, 32'h100, 32'h40,  1, 0, 32'h0,     1, 32'h90,   0, 32'h0,   9,  4);  // invalid
    cyc(0, 32'h100, 0,0,0, 32'h0,   32'h0,   0, 0, 32'h0,     1, 32'h90,   0, 32'h0,   9,  4);  // table unchanged
    cyc(0, 32'h100, 1,1,0, 32'h140, 32'h40,  1, 0, 32'h0,     1, 32'h90,   1, 32'h40,  9,  4);  // alias replaces
    cyc(0, 32'h100, 0,0,0, 32'h0,   32'h0,   0, 0, 32'h0,     0, 32'h104,  0, 32'h0,  10,  5);
    cyc(0, 32'h140, 0,0,0, 32'h0,   32'h0,   0, 0, 32'h0,     1, 32'h40,   0, 32'h0,  10,  5);
    cyc(0, 32'h204, 1,1,0, 32'h204, 32'h300, 0, 0, 32'h0,     0, 32'h208,  0, 32'h0,  10,  5);  // miss not taken
    cyc(0, 32'h204, 0,0,0, 32'h0,   32'h0,   0, 0, 32'h0,     0, 32'h208,  0, 32'h0,  11,  5);
    cyc(1, 32'h140, 1,1,0, 32'h140, 32'h40,  0, 1, 32'h40,    0, 32'h144,  0, 32'h0,  11,  5);  // reset mid-op
    cyc(0, 32'h140, 0,0,0, 32'h0,   32'h0,   0, 0, 32'h0,     0, 32'h144,  0, 32'h0,   0,  0);

    budget = 10;
    while (sb_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    if (checks == 0) begin
      failures++;
      $display("FAIL no_checks actual=0 required>0");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
